sprite_frame_animator: RTL and testbench
========================================

Name: sprite_frame_animator

Overview:
Parametrised sprite animator, successor to the fixed two-frame per-tank animator FSMs. Watches an N-slot USB keycode bus for one player's four movement keys and latches the facing direction. While moving, it steps a multi-frame animation index at a programmable rate derived from a frame-tick strobe, in loop or ping-pong mode. One instance per tank; frame_idx and direction feed the sprite ROM address mux.

Parameters:
NUM_FRAMES, 2, animation frames per direction (>=1)
FRAME_W, 1, width of frame_idx; must satisfy 2**FRAME_W >= NUM_FRAMES
HOLD_TICKS, 1, frame_tick strobes per frame advance (>=1)
NUM_KEYS, 4, keycode slots on the bus
PINGPONG, 0, 0 = loop 0..N-1,0; 1 = bounce 0..N-1..0
IDLE_RESET, 1, 1 = frame_idx returns to 0 when idle; 0 = frame_idx freezes
KEY_UP, 8'h1A, up keycode (nonzero)
KEY_LEFT, 8'h04, left keycode (nonzero)
KEY_DOWN, 8'h16, down keycode (nonzero)
KEY_RIGHT, 8'h07, right keycode (nonzero)

Ports:
animator_clock  in  1  sole clock
animator_reset_n  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle animation-rate strobe (e.g. vsync edge)
enable  in  1  0 = hold all state (pause); reset still applies
keycode_bus  in  8*NUM_KEYS  slot k at bits [8k+7:8k]; 8'h00 = empty slot
frame_idx  out  FRAME_W  current animation frame
moving  out  1  registered: a movement key was held last cycle
direction  out  2  00 up, 01 left, 10 down, 11 right; last facing
wrap_pulse  out  1  one-cycle pulse when frame_idx advances into 0

Behaviour:
- Clock and reset: one clock, animator_clock. Reset is synchronous and active-low: animator_reset_n is sampled on the rising edge of animator_clock. On reset: frame_idx=0, moving=0, direction=00, wrap_pulse=0, hold counter=0, ping-pong sense=up, state=IDLE. Reset overrides enable and frame_tick.
- Key decode (combinational): a key is held if any slot equals its code. any_key = OR of the four.
- Direction priority when several keys are held: up > left > down > right.
- Direction timing: direction registers the decoded key on the edge after it appears. When no key is held, direction keeps its last value.
- FSM states IDLE and MOVING, evaluated every clock while enable=1:
  - IDLE -> MOVING when any_key.
  - MOVING -> IDLE when !any_key.
  - moving = (state == MOVING), so it lags the keys by one cycle.
- Hold counter:
  - Counts only on frame_tick && state==MOVING && enable.
  - When it is HOLD_TICKS-1 on a tick, it clears to 0 and frame_idx advances that same edge.
- Loop mode (PINGPONG=0): advance from NUM_FRAMES-1 goes to 0. wrap_pulse=1 for that cycle.
- Ping-pong mode (PINGPONG=1):
  - Sense flips at NUM_FRAMES-1 and at 0; the end frame is shown once per bounce.
  - Sequence for N=3: 0,1,2,1,0,1,...
  - wrap_pulse fires on each advance into 0.
- NUM_FRAMES=1: frame_idx stays 0, wrap_pulse never asserts, and the hold counter still runs.
- NUM_FRAMES=2 with HOLD_TICKS=1 in either mode toggles frame_idx on every tick while moving.
- MOVING->IDLE transition edge:
  - IDLE_RESET=1: frame_idx=0, hold counter=0, ping-pong sense=up.
  - IDLE_RESET=0: frame_idx and sense are held, and the hold counter clears.
  - No wrap_pulse is generated by this idle reset.
- Tick on the same edge as IDLE->MOVING: no advance, because the current state is IDLE. The first advance needs HOLD_TICKS ticks in MOVING.
- Tick on the same edge as MOVING->IDLE: the advance for that edge still applies. With IDLE_RESET=1 the reset-to-0 takes precedence and there is no wrap_pulse.
- enable=0: all registers hold and wrap_pulse=0. Key and tick activity is ignored.
- Reset mid-animation: all outputs return to reset values on the next edge. Keys still held cause IDLE->MOVING on the first edge after release.
- Unlisted keycodes and 8'h00 slots are ignored. Duplicate codes across slots are harmless.

Test Plan:
- Reset with key 8'h1A held in slot 2 -> during reset all outputs 0. First edge after release: moving=1, direction=00, frame_idx=0.
- Defaults, hold 8'h07, 5 ticks -> frame_idx 1,0,1,0,1. wrap_pulse on ticks 2 and 4. direction=11.
- NUM_FRAMES=3, PINGPONG=1, HOLD_TICKS=2, hold 8'h16, 12 ticks -> frame_idx changes every 2nd tick: 1,2,1,0,1,2. wrap_pulse once, on the advance into 0.
- Keys 8'h04 and 8'h1A held together, then 8'h1A released -> direction=00, then 01. Release all -> direction stays 01, moving=0.
- NUM_FRAMES=4, IDLE_RESET=1, release keys at frame 2 -> next edge frame_idx=0, no wrap_pulse. Repeat with IDLE_RESET=0 -> frame_idx stays 2 and resumes from 3.
- Moving at frame 1, enable=0 for 3 ticks -> frame_idx stays 1. enable=1 -> next tick advances. Tick coincident with key press from IDLE -> no advance.

Source files
------------

// File: rtl/sprite_frame_animator.sv
// Per-tank sprite animator: decodes one player's movement keys from a keycode bus,
// latches facing direction and steps a loop or ping-pong frame index while moving.
module sprite_frame_animator #(
    parameter int          NUM_FRAMES = 2,
    parameter int          FRAME_W    = 1,
    parameter int          HOLD_TICKS = 1,
    parameter int          NUM_KEYS   = 4,
    parameter int          PINGPONG   = 0,
    parameter int          IDLE_RESET = 1,
    parameter logic [7:0]  KEY_UP     = 8'h1A,
    parameter logic [7:0]  KEY_LEFT   = 8'h04,
    parameter logic [7:0]  KEY_DOWN   = 8'h16,
    parameter logic [7:0]  KEY_RIGHT  = 8'h07
) (
    input  logic                    animator_clock,
    input  logic                    animator_reset_n,
    input  logic                    frame_tick,
    input  logic                    enable,
    input  logic [8*NUM_KEYS-1:0]   keycode_bus,
    output logic [FRAME_W-1:0]      frame_idx,
    output logic                    moving,
    output logic [1:0]              direction,
    output logic                    wrap_pulse
);

    localparam int                 HOLD_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic [1:0]         dir_q,   dir_d;
    logic               sense_q, sense_d;   // 0 = counting up, 1 = counting down
    logic               wrap_q,  wrap_d;

    logic               key_up_s, key_left_s, key_down_s, key_right_s, any_key_s;
    logic [1:0]         dir_key_s;
    logic [FRAME_W-1:0] frame_step_s;
    logic               sense_step_s, wrap_step_s, go_down_s;

    // Key decode: a key counts as held if any slot carries its code.
    always_comb begin
        key_up_s    = 1'b0;
        key_left_s  = 1'b0;
        key_down_s  = 1'b0;
        key_right_s = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keycode_bus[8*k +: 8] == KEY_UP) begin
                key_up_s = 1'b1;
            end else begin
                key_up_s = key_up_s;
            end
            if (keycode_bus[8*k +: 8] == KEY_LEFT) begin
                key_left_s = 1'b1;
            end else begin
                key_left_s = key_left_s;
            end
            if (keycode_bus[8*k +: 8] == KEY_DOWN) begin
                key_down_s = 1'b1;
            end else begin
                key_down_s = key_down_s;
            end
            if (keycode_bus[8*k +: 8] == KEY_RIGHT) begin
                key_right_s = 1'b1;
            end else begin
                key_right_s = key_right_s;
            end
        end
        any_key_s = key_up_s | key_left_s | key_down_s | key_right_s;
    end

    // Facing priority: up beats left beats down beats right.
    always_comb begin
        dir_key_s = dir_q;
        if (key_up_s) begin
            dir_key_s = 2'b00;
        end else if (key_left_s) begin
            dir_key_s = 2'b01;
        end else if (key_down_s) begin
            dir_key_s = 2'b10;
        end else if (key_right_s) begin
            dir_key_s = 2'b11;
        end else begin
            dir_key_s = dir_q;
        end
    end

    // Candidate next frame if this edge advances the animation.
    always_comb begin
        frame_step_s = frame_q;
        sense_step_s = sense_q;
        wrap_step_s  = 1'b0;
        go_down_s    = 1'b0;
        if (NUM_FRAMES <= 1) begin
            frame_step_s = FRAME_ZERO;
            sense_step_s = 1'b0;
        end else if (PINGPONG == 0) begin
            if (frame_q >= LAST_FRAME) begin
                frame_step_s = FRAME_ZERO;
                wrap_step_s  = 1'b1;
            end else begin
                frame_step_s = frame_q + FRAME_ONE;
            end
        end else begin
            // The end frames flip the sense so each is shown once per bounce.
            go_down_s = (sense_q && (frame_q != FRAME_ZERO)) || (frame_q >= LAST_FRAME);
            if (go_down_s) begin
                frame_step_s = frame_q - FRAME_ONE;
            end else begin
                frame_step_s = frame_q + FRAME_ONE;
            end
            if (frame_step_s == LAST_FRAME) begin
                sense_step_s = 1'b1;
            end else if (frame_step_s == FRAME_ZERO) begin
                sense_step_s = 1'b0;
            end else begin
                sense_step_s = go_down_s;
            end
            wrap_step_s = (frame_step_s == FRAME_ZERO);
        end
    end

    // Next-state: FSM, hold counter, frame stepping and idle handling.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        sense_d = sense_q;
        wrap_d  = 1'b0;
        if (enable) begin
            if (any_key_s) begin
                state_d = ST_MOVING;
                dir_d   = dir_key_s;
            end else begin
                state_d = ST_IDLE;
                dir_d   = dir_q;
            end
            if (frame_tick && (state_q == ST_MOVING)) begin
                if (hold_q >= HOLD_LAST) begin
                    hold_d  = {HOLD_W{1'b0}};
                    frame_d = frame_step_s;
                    sense_d = sense_step_s;
                    wrap_d  = wrap_step_s;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end else begin
                hold_d = hold_q;
            end
            // Leaving MOVING: an idle reset overrides any advance on the same edge.
            if ((state_q == ST_MOVING) && !any_key_s) begin
                hold_d = {HOLD_W{1'b0}};
                if (IDLE_RESET != 0) begin
                    frame_d = FRAME_ZERO;
                    sense_d = 1'b0;
                    wrap_d  = 1'b0;
                end else begin
                    frame_d = frame_d;
                end
            end else begin
                hold_d = hold_d;
            end
        end else begin
            wrap_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge animator_clock) begin
        if (!animator_reset_n) begin
            state_q <= ST_IDLE;
            frame_q <= FRAME_ZERO;
            hold_q  <= {HOLD_W{1'b0}};
            dir_q   <= 2'b00;
            sense_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            sense_q <= sense_d;
            wrap_q  <= wrap_d;
        end
    end

    assign frame_idx  = frame_q;
    assign moving     = (state_q == ST_MOVING);
    assign direction  = dir_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_sprite_frame_animator.sv
// Bench for sprite_frame_animator: six parameter variants on a shared bus, checked
// every cycle against an advance-count model, plus directed literal scenarios.
module tb_sprite_frame_animator;

    logic        clk = 1'b0;
    logic        rst_n, en, tick;
    logic [31:0] bus;

    logic [0:0]  f0, f4;
    logic [1:0]  f1, f2, f3;
    logic [2:0]  f5;
    logic [5:0]  mv, wp;
    logic [1:0]  dr [6];

    always #5 clk = ~clk;

    sprite_frame_animator #(.NUM_FRAMES(2), .FRAME_W(1), .HOLD_TICKS(1), .PINGPONG(0), .IDLE_RESET(1)) u0 (
        .animator_clock(clk), .animator_reset_n(rst_n), .frame_tick(tick), .enable(en),
        .keycode_bus(bus), .frame_idx(f0), .moving(mv[0]), .direction(dr[0]), .wrap_pulse(wp[0]));
    sprite_frame_animator #(.NUM_FRAMES(3), .FRAME_W(2), .HOLD_TICKS(2), .PINGPONG(1), .IDLE_RESET(1)) u1 (
        .animator_clock(clk), .animator_reset_n(rst_n), .frame_tick(tick), .enable(en),
        .keycode_bus(bus), .frame_idx(f1), .moving(mv[1]), .direction(dr[1]), .wrap_pulse(wp[1]));
    sprite_frame_animator #(.NUM_FRAMES(4), .FRAME_W(2), .HOLD_TICKS(1), .PINGPONG(0), .IDLE_RESET(1)) u2 (
        .animator_clock(clk), .animator_reset_n(rst_n), .frame_tick(tick), .enable(en),
        .keycode_bus(bus), .frame_idx(f2), .moving(mv[2]), .direction(dr[2]), .wrap_pulse(wp[2]));
    sprite_frame_animator #(.NUM_FRAMES(4), .FRAME_W(2), .HOLD_TICKS(1), .PINGPONG(0), .IDLE_RESET(0)) u3 (
        .animator_clock(clk), .animator_reset_n(rst_n), .frame_tick(tick), .enable(en),
        .keycode_bus(bus), .frame_idx(f3), .moving(mv[3]), .direction(dr[3]), .wrap_pulse(wp[3]));
    sprite_frame_animator #(.NUM_FRAMES(1), .FRAME_W(1), .HOLD_TICKS(3), .PINGPONG(0), .IDLE_RESET(1)) u4 (
        .animator_clock(clk), .animator_reset_n(rst_n), .frame_tick(tick), .enable(en),
        .keycode_bus(bus), .frame_idx(f4), .moving(mv[4]), .direction(dr[4]), .wrap_pulse(wp[4]));
    sprite_frame_animator #(.NUM_FRAMES(5), .FRAME_W(3), .HOLD_TICKS(1), .PINGPONG(1), .IDLE_RESET(0),
                            .KEY_UP(8'h52), .KEY_LEFT(8'h50), .KEY_DOWN(8'h51), .KEY_RIGHT(8'h4F)) u5 (
        .animator_clock(clk), .animator_reset_n(rst_n), .frame_tick(tick), .enable(en),
        .keycode_bus(bus), .frame_idx(f5), .moving(mv[5]), .direction(dr[5]), .wrap_pulse(wp[5]));

    int nf [6] = '{2, 3, 4, 4, 1, 5};
    int ht [6] = '{1, 2, 1, 1, 3, 1};
    int pp [6] = '{0, 1, 0, 0, 0, 1};
    int ir [6] = '{1, 1, 1, 0, 1, 0};
    logic [7:0] std_keys [4] = '{8'h1A, 8'h04, 8'h16, 8'h07};
    logic [7:0] alt_keys [4] = '{8'h52, 8'h50, 8'h51, 8'h4F};
    logic [7:0] pool [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h1A, 8'h04, 8'h16, 8'h07,
                              8'h52, 8'h50, 8'h51, 8'h4F, 8'h33};

    // Model: number of frame advances since the last return to 0, plus tick count.
    int m_mov [6], m_dir [6], m_adv [6], m_hold [6], m_wrap [6];
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic int frame_of(input int i, input int adv);
        int per, p;
        if (nf[i] <= 1) return 0;
        if (pp[i] == 0) return adv % nf[i];
        per = 2 * nf[i] - 2;
        p = adv % per;
        return (p < nf[i]) ? p : per - p;
    endfunction

    function automatic int act_frame(input int i);
        case (i)
            0: return int'(f0);
            1: return int'(f1);
            2: return int'(f2);
            3: return int'(f3);
            4: return int'(f4);
            5: return int'(f5);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 6; i++) begin
            bit held [4];
            bit any;
            int dnew;
            if (!rst_n) begin
                m_mov[i] = 0; m_dir[i] = 0; m_adv[i] = 0; m_hold[i] = 0; m_wrap[i] = 0;
            end else if (!en) begin
                m_wrap[i] = 0;
            end else begin
                any = 1'b0;
                dnew = -1;
                for (int k = 0; k < 4; k++) begin
                    held[k] = 1'b0;
                    for (int s = 0; s < 4; s++)
                        if (bus[8*s +: 8] == ((i == 5) ? alt_keys[k] : std_keys[k])) held[k] = 1'b1;
                    if (held[k]) begin
                        any = 1'b1;
                        if (dnew < 0) dnew = k;
                    end
                end
                if (any) m_dir[i] = dnew;
                m_wrap[i] = 0;
                if (tick && m_mov[i] != 0) begin
                    m_hold[i]++;
                    if (m_hold[i] == ht[i]) begin
                        m_hold[i] = 0;
                        if (nf[i] > 1) begin
                            m_adv[i] = (m_adv[i] + 1) % ((pp[i] != 0) ? 2 * nf[i] - 2 : nf[i]);
                            m_wrap[i] = (frame_of(i, m_adv[i]) == 0) ? 1 : 0;
                        end
                    end
                end
                if (m_mov[i] != 0 && !any) begin
                    m_hold[i] = 0;
                    if (ir[i] != 0) begin
                        m_adv[i] = 0;
                        m_wrap[i] = 0;
                    end
                end
                m_mov[i] = any ? 1 : 0;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic t, input logic [31:0] b);
        rst_n = r; en = e; tick = t; bus = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("u%0d.frame_idx", i), act_frame(i), frame_of(i, m_adv[i]));
                chk($sformatf("u%0d.moving", i), int'(mv[i]), m_mov[i]);
                chk($sformatf("u%0d.direction", i), int'(dr[i]), m_dir[i]);
                chk($sformatf("u%0d.wrap_pulse", i), int'(wp[i]), m_wrap[i]);
            end
        end
    end

    initial begin
        int exp1 [12] = '{0, 1, 1, 2, 2, 1, 1, 0, 0, 1, 1, 2};
        logic [31:0] rb;
        logic r, e, t;
        rst_n = 1'b0; en = 1'b1; tick = 1'b0; bus = 32'h0;

        // Reset with up key in slot 2, then release.
        cyc(1'b0, 1'b1, 1'b1, 32'h001A_0000);
        chk_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'h001A_0000);
        chk("rst.moving", int'(mv[0]), 0);
        chk("rst.frame", int'(f0), 0);
        chk("rst.dir", int'(dr[0]), 0);
        chk("rst.wrap", int'(wp[0]), 0);
        cyc(1'b1, 1'b1, 1'b0, 32'h001A_0000);
        chk("rel.moving", int'(mv[0]), 1);
        chk("rel.dir", int'(dr[0]), 0);
        chk("rel.frame", int'(f0), 0);

        // Defaults: right key, five ticks.
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0007);
        for (int n = 0; n < 5; n++) begin
            cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
            chk("loop2.frame", int'(f0), (n % 2 == 0) ? 1 : 0);
            chk("loop2.wrap", int'(wp[0]), (n % 2 == 1) ? 1 : 0);
        end
        chk("loop2.dir", int'(dr[0]), 3);

        // Ping-pong N=3, hold 2, down key.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_1600);
        for (int n = 0; n < 12; n++) begin
            cyc(1'b1, 1'b1, 1'b1, 32'h0000_1600);
            chk("pp3.frame", int'(f1), exp1[n]);
            chk("pp3.wrap", int'(wp[1]), (n == 7) ? 1 : 0);
        end
        chk("pp3.dir", int'(dr[1]), 2);

        // Direction priority and release.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_041A);
        chk("prio.both", int'(dr[0]), 0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0400);
        chk("prio.left", int'(dr[0]), 1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("prio.keep", int'(dr[0]), 1);
        chk("prio.idle", int'(mv[0]), 0);

        // Idle reset versus freeze at frame 2.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0007);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        chk("idle.pre2", int'(f2), 2);
        chk("idle.pre3", int'(f3), 2);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("idle.rst_frame", int'(f2), 0);
        chk("idle.rst_wrap", int'(wp[2]), 0);
        chk("idle.frz_frame", int'(f3), 2);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0007);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        chk("idle.resume", int'(f3), 3);

        // Pause, resume, and tick coincident with key press.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0007);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        for (int n = 0; n < 3; n++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'h0);
            chk("pause.frame", int'(f0), 1);
            chk("pause.moving", int'(mv[0]), 1);
        end
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        chk("resume.frame", int'(f0), 0);
        chk("resume.wrap", int'(wp[0]), 1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        chk("press_tick.frame", int'(f0), 0);
        chk("press_tick.moving", int'(mv[0]), 1);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0007);
        chk("press_tick.next", int'(f0), 1);

        // Randomized phase.
        rb = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            e = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
            t = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                for (int s = 0; s < 4; s++) rb[8*s +: 8] = pool[$urandom_range(0, 12)];
            end
            cyc(r, e, t, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
